normalize_pipe: RTL and testbench

Pipelined, parametrised floating-point mantissa normaliser with a valid/ready handshake. It accepts an unnormalised mantissa (with optional carry-out bit from the adder), exponent and sticky bit. It returns the left- or right-normalised mantissa, the adjusted exponent and status flags. It sits between the mantissa add/sub stage and the rounding stage of the FP datapath, and replaces the single-cycle combinational normaliser on the critical path.

---
 rtl/norm_pkg.sv | 19 +
 rtl/norm_lzc.sv | 25 ++
 rtl/normalize_pipe.sv | 166 ++++++++++++++++
 tb/tb_normalize_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and helpers for the pipelined mantissa normaliser.
package norm_pkg;

  function automatic int calc_shift_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    SEL_LEFT  = 2'd0,
    SEL_RIGHT = 2'd1,
    SEL_ZERO  = 2'd2
  } sel_e;

  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_DENORM = 1;
  localparam int FLAG_OVF    = 2;
  localparam int FLAG_W      = 3;

endpackage

// File: rtl/norm_lzc.sv
// Priority leading-zero counter: position of the first 1 counted from the MSB.
module norm_lzc
  import norm_pkg::*;
#(
  parameter int WIDTH   = 26,
  parameter int SHIFT_W = calc_shift_w(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  output logic [SHIFT_W-1:0] count,
  output logic               all_zero
);

  // count is WIDTH when no bit is set; callers use all_zero for that case
  always_comb begin
    count    = SHIFT_W'(WIDTH);
    all_zero = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (all_zero && data[i]) begin
        count    = SHIFT_W'(WIDTH - 1 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/normalize_pipe.sv
// Two-stage FP mantissa normaliser: S1 picks the shift, S2 applies it and
// registers the result with exponent adjustment and status flags.
module normalize_pipe
  import norm_pkg::*;
#(
  parameter int SIZE_MANTIS = 26,
  parameter int SIZE_EXP    = 8,
  parameter int SHIFT_W     = calc_shift_w(SIZE_MANTIS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   carry_in,
  input  logic [SIZE_EXP-1:0]    exp_in,
  input  logic [SIZE_MANTIS-1:0] mantis_in,
  input  logic                   sticky_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE_EXP-1:0]    exp_out,
  output logic [SIZE_MANTIS-1:0] mantis_out,
  output logic                   sticky_out,
  output logic                   flag_zero,
  output logic                   flag_denorm,
  output logic                   flag_ovf
);

  localparam int CW = (SIZE_EXP > SHIFT_W) ? SIZE_EXP : SHIFT_W;
  localparam logic [SIZE_EXP-1:0] EXP_MAX = {SIZE_EXP{1'b1}};
  localparam logic [SIZE_EXP-1:0] EXP_SAT = {{(SIZE_EXP-1){1'b1}}, 1'b0};

  // Handshake: a stage moves when its data is taken or it is empty.
  // Transfer happens on a rising edge with valid && ready; in_ready is
  // combinational from out_ready (no skid buffer), outputs hold while stalled.
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ---------------- Stage 1: shift decision ----------------
  logic [SHIFT_W-1:0] lz;
  logic               mant_zero;

  norm_lzc #(.WIDTH(SIZE_MANTIS), .SHIFT_W(SHIFT_W)) u_lzc (
    .data     (mantis_in),
    .count    (lz),
    .all_zero (mant_zero)
  );

  sel_e               sel_d;
  logic [SHIFT_W-1:0] shift_d;
  logic               denorm_d;

  always_comb begin
    sel_d    = SEL_LEFT;
    shift_d  = '0;
    denorm_d = 1'b0;
    if (carry_in) begin
      sel_d = SEL_RIGHT;
    end else if (mant_zero) begin
      sel_d = SEL_ZERO;
    end else begin
      // exp_in < lz here, so truncating exp_in to SHIFT_W bits is lossless
      if (CW'(lz) > CW'(exp_in)) begin
        shift_d  = SHIFT_W'(exp_in);
        denorm_d = 1'b1;
      end else begin
        shift_d = lz;
      end
      if (exp_in == '0) denorm_d = 1'b1;
    end
  end

  sel_e                   s1_sel;
  logic [SHIFT_W-1:0]     s1_shift;
  logic                   s1_denorm;
  logic [SIZE_EXP-1:0]    s1_exp;
  logic [SIZE_MANTIS-1:0] s1_mantis;
  logic                   s1_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sel    <= SEL_LEFT;
      s1_shift  <= '0;
      s1_denorm <= 1'b0;
      s1_exp    <= '0;
      s1_mantis <= '0;
      s1_sticky <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sel    <= sel_d;
        s1_shift  <= shift_d;
        s1_denorm <= denorm_d;
        s1_exp    <= exp_in;
        s1_mantis <= mantis_in;
        s1_sticky <= sticky_in;
      end
    end
  end

  // ---------------- Stage 2: apply shift ----------------
  logic [CW-1:0]          exp_sub;
  logic [SIZE_EXP-1:0]    exp_d;
  logic [SIZE_MANTIS-1:0] mantis_d;
  logic                   sticky_d;
  logic [FLAG_W-1:0]      flags_d;

  assign exp_sub = CW'(s1_exp) - CW'(s1_shift);

  always_comb begin
    exp_d    = '0;
    mantis_d = '0;
    sticky_d = s1_sticky;
    flags_d  = '0;
    case (s1_sel)
      SEL_RIGHT: begin
        mantis_d = {1'b1, s1_mantis[SIZE_MANTIS-1:1]};
        sticky_d = s1_sticky | s1_mantis[0];
        // saturate to infinity rather than wrapping the exponent
        if (s1_exp >= EXP_SAT) begin
          exp_d             = EXP_MAX;
          mantis_d          = '0;
          flags_d[FLAG_OVF] = 1'b1;
        end else begin
          exp_d = s1_exp + SIZE_EXP'(1);
        end
      end
      SEL_ZERO: begin
        flags_d[FLAG_ZERO] = 1'b1;
      end
      default: begin
        mantis_d             = s1_mantis << s1_shift;
        exp_d                = exp_sub[SIZE_EXP-1:0];
        flags_d[FLAG_DENORM] = s1_denorm;
      end
    endcase
  end

  logic [FLAG_W-1:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      exp_out    <= '0;
      mantis_out <= '0;
      sticky_out <= 1'b0;
      flags_q    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        exp_out    <= exp_d;
        mantis_out <= mantis_d;
        sticky_out <= sticky_d;
        flags_q    <= flags_d;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign flag_zero   = flags_q[FLAG_ZERO];
  assign flag_denorm = flags_q[FLAG_DENORM];
  assign flag_ovf    = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_normalize_pipe.sv
// Directed bench for normalize_pipe: single operands, boundaries, streaming,
// backpressure and mid-flight reset, each checked with immediate assertions.
module tb_normalize_pipe;

  localparam int W  = 26;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, carry_in, sticky_in;
  logic [EW-1:0] exp_in;
  logic [W-1:0]  mantis_in;
  logic          out_valid, out_ready;
  logic [EW-1:0] exp_out;
  logic [W-1:0]  mantis_out;
  logic          sticky_out, flag_zero, flag_denorm, flag_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  normalize_pipe #(.SIZE_MANTIS(W), .SIZE_EXP(EW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .carry_in    (carry_in),
    .exp_in      (exp_in),
    .mantis_in   (mantis_in),
    .sticky_in   (sticky_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .exp_out     (exp_out),
    .mantis_out  (mantis_out),
    .sticky_out  (sticky_out),
    .flag_zero   (flag_zero),
    .flag_denorm (flag_denorm),
    .flag_ovf    (flag_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // flags expected as {ovf, denorm, zero}
  task automatic check_out(input string tag, input logic [W-1:0] em, input logic [EW-1:0] ee,
                           input logic est, input logic [2:0] efl);
    chk({tag, ".valid"},  32'(out_valid), 32'd1);
    chk({tag, ".mantis"}, 32'(mantis_out), 32'(em));
    chk({tag, ".exp"},    32'(exp_out), 32'(ee));
    chk({tag, ".sticky"}, 32'(sticky_out), 32'(est));
    chk({tag, ".flags"},  32'({flag_ovf, flag_denorm, flag_zero}), 32'(efl));
  endtask

  task automatic set_in(input logic c, input logic [EW-1:0] e, input logic [W-1:0] m, input logic s);
    in_valid  = 1'b1;
    carry_in  = c;
    exp_in    = e;
    mantis_in = m;
    sticky_in = s;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    carry_in  = 1'b0;
    exp_in    = '0;
    mantis_in = '0;
    sticky_in = 1'b0;
  endtask

  // One operand through an otherwise idle pipe with out_ready high.
  task automatic run_one(input string tag, input logic c, input logic [EW-1:0] e,
                         input logic [W-1:0] m, input logic s,
                         input logic [W-1:0] em, input logic [EW-1:0] ee,
                         input logic est, input logic [2:0] efl);
    @(negedge clk);
    set_in(c, e, m, s);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    idle_in();
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_out(tag, em, ee, est, efl);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    chk("rst.valid",    32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.data",     32'({sticky_out, flag_ovf, flag_denorm, flag_zero, exp_out}), 32'd0);
    chk("rst.mantis",   32'(mantis_out), 32'd0);
    rst_n = 1'b1;

    run_one("left",     1'b0, 8'd20,  26'h0400000, 1'b0, 26'h2000000, 8'd17,  1'b0, 3'b000);
    run_one("denorm",   1'b0, 8'd5,   26'h0000001, 1'b0, 26'h0000020, 8'd0,   1'b0, 3'b010);
    run_one("carry",    1'b1, 8'd10,  26'h0000003, 1'b0, 26'h2000001, 8'd11,  1'b1, 3'b000);
    run_one("ovf_fe",   1'b1, 8'hFE,  26'h0000002, 1'b0, 26'h0000000, 8'hFF,  1'b0, 3'b100);
    run_one("ovf_ff",   1'b1, 8'hFF,  26'h3FFFFFF, 1'b1, 26'h0000000, 8'hFF,  1'b1, 3'b100);
    run_one("carry_fd", 1'b1, 8'hFD,  26'h2000000, 1'b0, 26'h3000000, 8'hFE,  1'b0, 3'b000);
    run_one("zero",     1'b0, 8'd40,  26'h0000000, 1'b1, 26'h0000000, 8'd0,   1'b1, 3'b001);
    run_one("exp0",     1'b0, 8'd0,   26'h0001000, 1'b0, 26'h0001000, 8'd0,   1'b0, 3'b010);
    run_one("lz_eq",    1'b0, 8'd17,  26'h0000100, 1'b0, 26'h2000000, 8'd0,   1'b0, 3'b000);
    run_one("norm_st",  1'b0, 8'd3,   26'h3FFFFFF, 1'b1, 26'h3FFFFFF, 8'd3,   1'b1, 3'b000);

    // Full-throughput stream: accept and emit in the same cycle.
    @(negedge clk);
    set_in(1'b0, 8'd20, 26'h0400000, 1'b0);
    @(negedge clk);
    chk("stream.rdy1", 32'(in_ready), 32'd1);
    set_in(1'b1, 8'd10, 26'h0000003, 1'b0);
    @(negedge clk);
    chk("stream.rdy2", 32'(in_ready), 32'd1);
    set_in(1'b0, 8'd40, 26'h0000000, 1'b0);
    check_out("stream.a", 26'h2000000, 8'd17, 1'b0, 3'b000);
    @(negedge clk);
    idle_in();
    check_out("stream.b", 26'h2000001, 8'd11, 1'b1, 3'b000);
    @(negedge clk);
    check_out("stream.c", 26'h0000000, 8'd0, 1'b0, 3'b001);
    @(negedge clk);
    chk("stream.drain", 32'(out_valid), 32'd0);

    // Backpressure: three operands offered, only two fit.
    out_ready = 1'b0;
    set_in(1'b0, 8'd20, 26'h0400000, 1'b0);
    @(negedge clk);
    chk("bp.rdy_b", 32'(in_ready), 32'd1);
    set_in(1'b1, 8'd10, 26'h0000003, 1'b0);
    @(negedge clk);
    set_in(1'b0, 8'd40, 26'h0000000, 1'b0);
    chk("bp.rdy_full", 32'(in_ready), 32'd0);
    check_out("bp.hold0", 26'h2000000, 8'd17, 1'b0, 3'b000);
    repeat (3) @(negedge clk);
    chk("bp.rdy_stall", 32'(in_ready), 32'd0);
    check_out("bp.hold3", 26'h2000000, 8'd17, 1'b0, 3'b000);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    idle_in();
    check_out("bp.b", 26'h2000001, 8'd11, 1'b1, 3'b000);
    @(negedge clk);
    check_out("bp.c", 26'h0000000, 8'd0, 1'b0, 3'b001);
    @(negedge clk);
    chk("bp.drain", 32'(out_valid), 32'd0);

    // Reset with two operands in flight.
    out_ready = 1'b0;
    set_in(1'b0, 8'd20, 26'h0400000, 1'b0);
    @(negedge clk);
    set_in(1'b1, 8'd10, 26'h0000003, 1'b1);
    @(negedge clk);
    idle_in();
    chk("rst2.full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2.valid",    32'(out_valid), 32'd0);
    chk("rst2.in_ready", 32'(in_ready), 32'd1);
    chk("rst2.mantis",   32'(mantis_out), 32'd0);
    chk("rst2.data",     32'({sticky_out, flag_ovf, flag_denorm, flag_zero, exp_out}), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst2.quiet%0d", i), 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
